branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Branch-condition evaluator for the MIPS CPU's execute/decode stage.
- Compares two register operands, or one operand against zero, according to a 3-bit branch opcode.
- Produces a combinational take-branch decision for the PC-select logic.
- Also provides a registered copy of the decision and branch statistics counters for pipeline debug and performance monitoring.

Parameters:
- WIDTH, 32, operand width in bits (two's complement).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din1  input  WIDTH  first operand (rs); the only operand used for compare-with-zero ops.
- din2  input  WIDTH  second operand (rt); used only by ops 0 and 1.
- braEnable  input  1  instruction in this stage is a branch; when 0 no branch is taken.
- braOp  input  3  branch condition select.
- takeBranch  output  1  combinational branch decision.
- takeBranchR  output  1  takeBranch registered by one cycle.
- braCount  output  CNT_WIDTH  number of evaluated branches since reset.
- takenCount  output  CNT_WIDTH  number of taken branches since reset.

Behaviour:

braOp decode (signed compare on din1):
- 0 BEQ: din1 == din2.
- 1 BNE: din1 != din2.
- 2 BGEZ: din1 >= 0, i.e. MSB of din1 == 0.
- 3 BGTZ: din1 > 0, i.e. MSB == 0 and din1 != 0.
- 4 BLEZ: din1 <= 0, i.e. MSB == 1 or din1 == 0.
- 5 BLTZ: din1 < 0, i.e. MSB == 1.
- 6, 7 reserved: condition false.

takeBranch:
- takeBranch = braEnable AND condition(braOp).
- Purely combinational with zero latency; independent of clk and rst_n.
- ops 0/1 compare all WIDTH bits; signedness is irrelevant for them.
- Ops 2-5 ignore din2 entirely.
- braEnable = 0 forces takeBranch = 0 for every braOp.

takeBranchR:
- Reset value 0.
- On each rising clk edge, captures the current takeBranch value.
- Latency is exactly one cycle.

braCount:
- Reset value 0.
- Increments by 1 on a rising edge when braEnable = 1 and braOp <= 5.
- Reserved ops do not count.

takenCount:
- Reset value 0.
- Increments by 1 on a rising edge when takeBranch = 1.
- Invariant: takenCount never exceeds braCount while neither counter has wrapped.

Counter rules:
- Both counters wrap modulo 2^CNT_WIDTH (all-ones + 1 -> 0). There is no saturation and no overflow flag.
- If both increment in the same cycle, both update in that cycle.

Reset:
- Asserting rst_n = 0 at any time, including mid-stream, immediately clears takeBranchR, braCount and takenCount, independent of clk.
- While rst_n = 0, registers hold 0; takeBranch still follows its inputs combinationally.
- The first counted edge is the first rising clk edge after rst_n returns to 1.

Other:
- X on din2 must not affect takeBranch for ops 2-7.
- No handshake; inputs are sampled continuously.

Test Plan:
- braEnable=1, din1=5, din2=5: braOp=0 -> takeBranch 1; braOp=1 -> 0. Then din1=4, din2=3: braOp=0 -> 0; braOp=1 -> 1.
- braEnable=1, sweep braOp 2..5 with din1 = -1 (0xFFFFFFFF) -> 0,0,1,1; din1 = 0 -> 1,0,1,0; din1 = 1 -> 1,1,0,0. Repeat with din1 = 0x80000000 -> 0,0,1,1 and din1 = 0x7FFFFFFF -> 1,1,0,0.
- braEnable=0 with every braOp 0..7 and operands that would otherwise branch -> takeBranch 0 and counters unchanged. braEnable=1 with braOp 6/7 -> takeBranch 0 and braCount unchanged.
- Clocked sequence after reset, one braOp per cycle: {0 equal, 1 equal, 5 with din1 = -3, 3 with din1 = 0}:
  - takeBranchR = takeBranch delayed one cycle: 1, 0, 1, 0.
  - After 4 edges: braCount = 4, takenCount = 2.
- Pull rst_n low between clock edges mid-sequence -> takeBranchR, braCount and takenCount read 0 immediately. After release, counting restarts from 0 on the next edge.
- Preload with CNT_WIDTH=4, then 16 taken BEQ cycles -> braCount and takenCount both wrap to 0.

Source files
------------

// File: rtl/branch_unit.sv
// Branch-condition evaluator: combinational take-branch decision plus a registered
// copy and wrap-around statistics counters for debug/performance monitoring.
module branch_unit #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din1,
    input  logic [WIDTH-1:0]     din2,
    input  logic                 braEnable,
    input  logic [2:0]           braOp,
    output logic                 takeBranch,
    output logic                 takeBranchR,
    output logic [CNT_WIDTH-1:0] braCount,
    output logic [CNT_WIDTH-1:0] takenCount
);

    logic                 w_cond;
    logic                 w_din1_neg;
    logic                 w_din1_zero;
    logic                 w_op_valid;
    logic                 r_take;
    logic [CNT_WIDTH-1:0] r_bra_cnt;
    logic [CNT_WIDTH-1:0] r_taken_cnt;

    assign w_din1_neg  = din1[WIDTH-1];
    assign w_din1_zero = (din1 == '0);
    assign w_op_valid  = (braOp <= 3'd5);

    // din2 is referenced only by the equality ops so it cannot disturb ops 2-7
    always_comb begin
        w_cond = 1'b0;
        case (braOp)
            3'd0:    w_cond = (din1 == din2);
            3'd1:    w_cond = (din1 != din2);
            3'd2:    w_cond = !w_din1_neg;
            3'd3:    w_cond = !w_din1_neg && !w_din1_zero;
            3'd4:    w_cond = w_din1_neg || w_din1_zero;
            3'd5:    w_cond = w_din1_neg;
            default: w_cond = 1'b0;
        endcase
    end

    assign takeBranch = braEnable && w_cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_take      <= 1'b0;
            r_bra_cnt   <= '0;
            r_taken_cnt <= '0;
        end else begin
            r_take <= takeBranch;
            if (braEnable && w_op_valid)
                r_bra_cnt <= r_bra_cnt + CNT_WIDTH'(1);
            if (takeBranch)
                r_taken_cnt <= r_taken_cnt + CNT_WIDTH'(1);
        end
    end

    assign takeBranchR = r_take;
    assign braCount    = r_bra_cnt;
    assign takenCount  = r_taken_cnt;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit (default and 4-bit counter builds).
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din1, din2;
    logic        braEnable;
    logic [2:0]  braOp;

    logic        take_a, take_r_a;
    logic [15:0] bra_cnt_a, taken_cnt_a;
    logic        take_b, take_r_b;
    logic [3:0]  bra_cnt_b, taken_cnt_b;

    int total = 0;
    int bad   = 0;

    branch_unit #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .din1(din1), .din2(din2),
        .braEnable(braEnable), .braOp(braOp),
        .takeBranch(take_a), .takeBranchR(take_r_a),
        .braCount(bra_cnt_a), .takenCount(taken_cnt_a)
    );

    branch_unit #(.WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .din1(din1), .din2(din2),
        .braEnable(braEnable), .braOp(braOp),
        .takeBranch(take_b), .takeBranchR(take_r_b),
        .braCount(bra_cnt_b), .takenCount(taken_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] sweep_din1 [5] = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF};
    // expected for ops 2,3,4,5 packed as bits [3:0] = {op2,op3,op4,op5}
    logic [3:0]  sweep_exp  [5] = '{4'b0011, 4'b1010, 4'b1100, 4'b0011, 4'b1100};
    logic [2:0]  seq_op     [4] = '{3'd0, 3'd1, 3'd5, 3'd3};
    logic [31:0] seq_din1   [4] = '{32'd7, 32'd7, 32'hFFFF_FFFD, 32'd0};
    logic        seq_exp    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    logic [15:0] snap_bra, snap_taken;
    logic [3:0]  exp_bits;

    initial begin
        rst_n = 1'b0; din1 = '0; din2 = '0; braEnable = 1'b0; braOp = '0;
        #12;
        chk("rst_takeR", 32'(take_r_a), 32'd0);
        chk("rst_braCount", 32'(bra_cnt_a), 32'd0);
        chk("rst_takenCount", 32'(taken_cnt_a), 32'd0);
        braEnable = 1'b1; din1 = 32'd9; din2 = 32'd9; braOp = 3'd0;
        #1 chk("rst_comb_follow", 32'(take_a), 32'd1);

        @(negedge clk) rst_n = 1'b1;

        // equality ops
        din1 = 32'd5; din2 = 32'd5; braOp = 3'd0; #1 chk("beq_eq", 32'(take_a), 32'd1);
        braOp = 3'd1; #1 chk("bne_eq", 32'(take_a), 32'd0);
        din1 = 32'd4; din2 = 32'd3; braOp = 3'd0; #1 chk("beq_ne", 32'(take_a), 32'd0);
        braOp = 3'd1; #1 chk("bne_ne", 32'(take_a), 32'd1);
        din1 = 32'h8000_0001; din2 = 32'h0000_0001; braOp = 3'd0;
        #1 chk("beq_msb_only", 32'(take_a), 32'd0);

        // zero-compare sweep, din2 set to a distracting value
        for (int v = 0; v < 5; v++) begin
            exp_bits = sweep_exp[v];
            din1 = sweep_din1[v];
            din2 = ~sweep_din1[v];
            for (int k = 0; k < 4; k++) begin
                braOp = 3'(k + 2);
                #1 chk($sformatf("zcmp_%08h_op%0d", sweep_din1[v], k + 2),
                       32'(take_a), 32'(exp_bits[3-k]));
            end
        end

        // braEnable = 0 across every op: no branch, no counting
        @(negedge clk);
        din1 = 32'd5; din2 = 32'd5; braEnable = 1'b0;
        snap_bra = bra_cnt_a; snap_taken = taken_cnt_a;
        for (int k = 0; k < 8; k++) begin
            braOp = 3'(k);
            #1 chk($sformatf("disabled_op%0d", k), 32'(take_a), 32'd0);
            @(negedge clk);
        end
        chk("disabled_braCount", 32'(bra_cnt_a), 32'(snap_bra));
        chk("disabled_takenCount", 32'(taken_cnt_a), 32'(snap_taken));

        // reserved ops
        braEnable = 1'b1;
        for (int k = 6; k < 8; k++) begin
            braOp = 3'(k);
            #1 chk($sformatf("reserved_op%0d", k), 32'(take_a), 32'd0);
            @(negedge clk);
        end
        chk("reserved_braCount", 32'(bra_cnt_a), 32'(snap_bra));
        chk("reserved_takenCount", 32'(taken_cnt_a), 32'(snap_taken));

        // clocked sequence from a fresh reset
        braEnable = 1'b0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        braEnable = 1'b1; din2 = 32'd7;
        for (int k = 0; k < 4; k++) begin
            braOp = seq_op[k]; din1 = seq_din1[k];
            @(negedge clk);
            chk($sformatf("seq_takeR_%0d", k), 32'(take_r_a), 32'(seq_exp[k]));
        end
        chk("seq_braCount", 32'(bra_cnt_a), 32'd4);
        chk("seq_takenCount", 32'(taken_cnt_a), 32'd2);

        // mid-stream async reset between edges
        braOp = 3'd0; din1 = 32'd7;
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_takeR", 32'(take_r_a), 32'd0);
        chk("midrst_braCount", 32'(bra_cnt_a), 32'd0);
        chk("midrst_takenCount", 32'(taken_cnt_a), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("restart_braCount", 32'(bra_cnt_a), 32'd1);
        chk("restart_takenCount", 32'(taken_cnt_a), 32'd1);
        chk("restart_takeR", 32'(take_r_a), 32'd1);

        // 4-bit counter wrap after 16 taken BEQ cycles
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int k = 0; k < 15; k++) @(negedge clk);
        chk("wrap4_braCount_15", 32'(bra_cnt_b), 32'd15);
        chk("wrap4_takenCount_15", 32'(taken_cnt_b), 32'd15);
        @(negedge clk);
        chk("wrap4_braCount_0", 32'(bra_cnt_b), 32'd0);
        chk("wrap4_takenCount_0", 32'(taken_cnt_b), 32'd0);
        chk("wide_braCount_16", 32'(bra_cnt_a), 32'd16);
        chk("wide_takenCount_16", 32'(taken_cnt_a), 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
